// File: rtl/m_mux_nway_reg.sv
// N-channel registered multiplexer with valid/ready handshakes on every port.
// One input channel is granted per transfer, either by explicit select
// (MODE 0) or round-robin over the valid channels (MODE 1). The chosen word
// sits in the output register until the consumer accepts it.
module m_mux_nway_reg #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = 0,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       o_ready,
    input  logic [SELW-1:0]           i_sel,
    output logic [WIDTH-1:0]          o_data,
    output logic [SELW-1:0]           o_chan,
    output logic                      o_valid,
    input  logic                      i_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant_idx;
    logic            grant;
    logic            load_en;
    logic            xfer;

    // Pick the channel to serve this cycle, independent of output-side space.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        grant     = 1'b0;
        grant_idx = '0;
        if (MODE == 0) begin
            // An out-of-range select matches no k, so it simply yields no grant.
            for (int k = 0; k < CHANNELS; k++) begin
                if (i_sel == SELW'(k) && i_valid[k]) begin
                    grant     = 1'b1;
                    grant_idx = SELW'(k);
                end
            end
        end else begin
            // Scan from the far end back towards ptr so the channel closest
            // to ptr (in wrap order) is the last, and therefore winning, write.
            for (int off = CHANNELS - 1; off >= 0; off--) begin
                int idx;
                idx = (int'(ptr) + off) % CHANNELS;
                if (i_valid[idx]) begin
                    grant     = 1'b1;
                    grant_idx = SELW'(idx);
                end
            end
        end
    end

    // Handshake generation and EMPTY/FULL next-state decode.
    always_comb begin
        state_nxt = state;
        load_en   = (state == EMPTY) || i_ready;
        xfer      = load_en && grant;
        o_ready   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            o_ready[k] = xfer && (grant_idx == SELW'(k));
        end
        case (state)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL:    if (i_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign o_valid = (state == FULL);

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word, source index and round-robin pointer; updated only on an input transfer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_chan <= '0;
            ptr    <= '0;
        end else if (xfer) begin
            o_data <= i_data[int'(grant_idx)*WIDTH +: WIDTH];
            o_chan <= grant_idx;
            ptr    <= (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_m_mux_nway_reg.sv
// Bench for m_mux_nway_reg: three instances (explicit select N=4, round-robin
// N=4, explicit select N=3) run side by side against a behavioural model of
// the held word, source channel and round-robin pointer.
module tb_m_mux_nway_reg;

    localparam int NI = 3;
    localparam int MODEV[NI] = '{0, 1, 0};
    localparam int NCH[NI]   = '{4, 4, 3};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI-1:0][63:0] din;
    logic [NI-1:0][3:0]  vin;
    logic [NI-1:0][1:0]  sel;
    logic [NI-1:0]       rdy;
    wire  [NI-1:0][3:0]  ordy;
    wire  [NI-1:0][15:0] odat;
    wire  [NI-1:0][1:0]  ochn;
    wire  [NI-1:0]       oval;

    m_mux_nway_reg #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u_m0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[0]), .i_valid(vin[0]),
        .o_ready(ordy[0]), .i_sel(sel[0]), .o_data(odat[0]), .o_chan(ochn[0]),
        .o_valid(oval[0]), .i_ready(rdy[0]));

    m_mux_nway_reg #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u_m1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[1]), .i_valid(vin[1]),
        .o_ready(ordy[1]), .i_sel(sel[1]), .o_data(odat[1]), .o_chan(ochn[1]),
        .o_valid(oval[1]), .i_ready(rdy[1]));

    m_mux_nway_reg #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u_m2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[2][47:0]), .i_valid(vin[2][2:0]),
        .o_ready(ordy[2][2:0]), .i_sel(sel[2]), .o_data(odat[2]), .o_chan(ochn[2]),
        .o_valid(oval[2]), .i_ready(rdy[2]));
    assign ordy[2][3] = 1'b0;

    // Reference model: what each instance is holding.
    int m_val[NI];
    int m_dat[NI];
    int m_chn[NI];
    int m_ptr[NI];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    // Channel granted by the rules, or -1 for none.
    function automatic int ref_grant(input int i);
        int n = NCH[i];
        if (MODEV[i] == 0) begin
            int s = int'(sel[i]);
            if (s < n && vin[i][s]) return s;
            return -1;
        end
        for (int off = 0; off < n; off++) begin
            int c = (m_ptr[i] + off) % n;
            if (vin[i][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ref_ready(input int i);
        int g = ref_grant(i);
        if (g >= 0 && (m_val[i] == 0 || rdy[i])) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    // One clock: check o_ready before the edge, advance the model at the
    // edge, check registered outputs just after it, return at the negedge.
    task automatic cycle();
        int         g[NI];
        logic [3:0] r[NI];
        #1;
        for (int i = 0; i < NI; i++) begin
            g[i] = ref_grant(i);
            r[i] = ref_ready(i);
            check("o_ready", i, 32'(ordy[i]), 32'(r[i]));
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_val[i] = 0; m_dat[i] = 0; m_chn[i] = 0; m_ptr[i] = 0;
            end else if (r[i] != 4'b0000) begin
                m_dat[i] = int'(din[i][g[i]*16 +: 16]);
                m_chn[i] = g[i];
                m_val[i] = 1;
                m_ptr[i] = (g[i] + 1) % NCH[i];
            end else if (rdy[i]) begin
                m_val[i] = 0;
            end
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            check("o_valid", i, 32'(oval[i]), 32'(m_val[i]));
            check("o_chan",  i, 32'(ochn[i]), 32'(m_chn[i]));
            check("o_data",  i, 32'(odat[i]), 32'(m_dat[i]));
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_a[5] = '{0, 1, 2, 3, 0};
        int exp_b[4] = '{1, 3, 1, 3};

        rst_n = 1'b0;
        din = '0; vin = '0; sel = '0; rdy = '0;
        for (int i = 0; i < NI; i++) begin
            m_val[i] = 0; m_dat[i] = 0; m_chn[i] = 0; m_ptr[i] = 0;
        end
        @(negedge clk);
        cycle();
        cycle();
        for (int i = 0; i < NI; i++) check("rst_valid", i, 32'(oval[i]), 0);
        rst_n = 1'b1;

        // Explicit select of a valid channel.
        vin[0] = 4'b0100; sel[0] = 2'd2; din[0][47:32] = 16'hBEEF; rdy[0] = 1'b1;
        #1 check("t1_ready", 0, 32'(ordy[0]), 32'b0100);
        cycle();
        check("t1_data",  0, 32'(odat[0]), 32'hBEEF);
        check("t1_chan",  0, 32'(ochn[0]), 2);
        check("t1_valid", 0, 32'(oval[0]), 1);

        // Select pointing at an idle channel, then an out-of-range select.
        sel[0] = 2'd1;
        #1 check("t2_ready", 0, 32'(ordy[0]), 0);
        cycle();
        check("t2_valid", 0, 32'(oval[0]), 0);
        vin[0] = '0;
        vin[2] = 4'b0111; sel[2] = 2'd3; rdy[2] = 1'b1;
        #1 check("t2_oor_ready", 2, 32'(ordy[2]), 0);
        cycle();
        check("t2_oor_valid", 2, 32'(oval[2]), 0);
        vin[2] = '0;

        // Backpressure holds the word; release loads the next with no bubble.
        vin[0] = 4'b0001; sel[0] = 2'd0; din[0][15:0] = 16'h1234; rdy[0] = 1'b1;
        cycle();
        check("t3_load", 0, 32'(odat[0]), 32'h1234);
        rdy[0] = 1'b0;
        repeat (5) begin
            din[0] = {$urandom, $urandom}; vin[0] = 4'($urandom); sel[0] = 2'($urandom);
            cycle();
            check("t3_hold_data",  0, 32'(odat[0]), 32'h1234);
            check("t3_hold_valid", 0, 32'(oval[0]), 1);
            check("t3_hold_ready", 0, 32'(ordy[0]), 0);
        end
        rdy[0] = 1'b1; sel[0] = 2'd1; vin[0] = 4'b0010; din[0][31:16] = 16'h5678;
        #1 check("t3_rel_ready", 0, 32'(ordy[0]), 32'b0010);
        cycle();
        check("t3_rel_data",  0, 32'(odat[0]), 32'h5678);
        check("t3_rel_valid", 0, 32'(oval[0]), 1);
        vin[0] = '0;
        cycle();

        // Round-robin over all channels, then over a sparse set.
        vin[1] = 4'b1111; rdy[1] = 1'b1; din[1] = {$urandom, $urandom};
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t4_rr_all", 1, 32'(ochn[1]), 32'(exp_a[k]));
        end
        vin[1] = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_rr_sparse", 1, 32'(ochn[1]), 32'(exp_b[k]));
        end

        // Pointer wraps after ch3, and idles without moving.
        vin[1] = 4'b0011;
        cycle();
        check("t5_wrap", 1, 32'(ochn[1]), 0);
        vin[1] = '0;
        repeat (3) cycle();
        check("t5_idle_valid", 1, 32'(oval[1]), 0);
        vin[1] = 4'b1111;
        cycle();
        check("t5_resume", 1, 32'(ochn[1]), 1);

        // Reset while full with every channel valid.
        vin[0] = 4'b1111; sel[0] = 2'd3; vin[2] = 4'b0111; sel[2] = 2'd0;
        rdy = '1;
        cycle();
        rdy = '0;
        cycle();
        rst_n = 1'b0;
        cycle();
        for (int i = 0; i < NI; i++) begin
            check("t6_valid", i, 32'(oval[i]), 0);
            check("t6_data",  i, 32'(odat[i]), 0);
            check("t6_chan",  i, 32'(ochn[i]), 0);
        end
        rst_n = 1'b1;
        rdy[1] = 1'b1; vin[1] = 4'b1111;
        cycle();
        check("t6_first_rr", 1, 32'(ochn[1]), 0);
        check("t6_first_valid", 1, 32'(oval[1]), 1);

        // Randomised traffic with occasional reset.
        repeat (400) begin
            rst_n = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < NI; i++) begin
                din[i] = {$urandom, $urandom};
                vin[i] = 4'($urandom);
                sel[i] = 2'($urandom);
                rdy[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
